// File: rtl/bmc_decoder.sv
// rtl/bmc_decoder.sv - biphase-mark decoder producing one word per light envelope
// Ports: clk, reset; d_in_0/d_in_1 half-bit samples; e_in envelope; enabled;
//        system_timestamp; decoded_data, data_availible, timestamp_last_data.
module bmc_decoder #(
    parameter int bit_considered = 17,
    parameter int TS_WIDTH       = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      d_in_0,
    input  logic                      d_in_1,
    input  logic                      e_in,
    input  logic                      enabled,
    input  logic [TS_WIDTH-1:0]       system_timestamp,
    output logic [bit_considered-1:0] decoded_data,
    output logic                      data_availible,
    output logic [TS_WIDTH-1:0]       timestamp_last_data
);

    localparam int CW = $clog2(bit_considered + 2);

    logic                      e_q;
    logic [bit_considered-1:0] shift;
    logic [CW-1:0]             count;
    logic [TS_WIDTH-1:0]       ts_start;
    logic                      bit_val;

    // A BMC '1' toggles mid-bit, so the two half-bit samples differ.
    assign bit_val = d_in_0 ^ d_in_1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q                 <= 1'b0;
            shift               <= '0;
            count               <= '0;
            ts_start            <= '0;
            decoded_data        <= '0;
            data_availible      <= 1'b0;
            timestamp_last_data <= '0;
        end else begin
            e_q <= e_in;
            if (e_in && !e_q) begin
                shift          <= {{(bit_considered-1){1'b0}}, bit_val};
                count          <= CW'(1);
                ts_start       <= system_timestamp;
                data_availible <= 1'b0;
            end else if (e_in) begin
                shift <= {shift[bit_considered-2:0], bit_val};
                if (count != CW'(bit_considered + 1)) begin
                    count <= count + 1'b1;
                end
            end else if (e_q && enabled && count == CW'(bit_considered)) begin
                // Only an envelope carrying exactly one full word is reported.
                decoded_data        <= shift;
                timestamp_last_data <= ts_start;
                data_availible      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ts4231_configurator.sv
// rtl/ts4231_configurator.sv - TS4231 pad configurator, one per receiver
// Ports: clk; e_in/d_in sensor pad readback; envelop_/data_output(_enable) pad drive; configured done flag.
module ts4231_configurator (
    input  logic clk,
    input  logic e_in,
    input  logic d_in,
    output logic envelop_output_enable,
    output logic envelop_output,
    output logic data_output_enable,
    output logic data_output,
    output logic configured
);

    // No reset: the sensor keeps its configuration across a logic reset,
    // so the done flag must survive as well. Both pads reading back high
    // is the sensor acknowledging that it has entered watch mode.
    always_ff @(posedge clk) begin
        if (e_in && d_in) begin
            configured <= 1'b1;
        end
    end

    // Hold the data pad low until the sensor acknowledges; envelope is input-only.
    assign envelop_output_enable = 1'b0;
    assign envelop_output        = 1'b0;
    assign data_output_enable    = ~configured;
    assign data_output           = 1'b0;

endmodule

// File: rtl/multi_receiver_manager.sv
// rtl/multi_receiver_manager.sv - N-channel TS4231 manager merging decoded words into one FWFT stream
// Ports: clk_96MHz, reset (async high); e_in/d_in_0/d_in_1 per-channel sensor inputs;
//        system_timestamp; channel_enable; pad outputs and configured per channel;
//        out_valid/out_ready/out_channel/out_data/out_timestamp stream; fifo_level;
//        overflow/drop_count sticky drop status, clear_overflow.
module multi_receiver_manager #(
    parameter int N_RECEIVERS = 4,
    parameter int DATA_BITS   = 17,
    parameter int TS_WIDTH    = 24,
    parameter int FIFO_DEPTH  = 8,
    localparam int CH_W  = (N_RECEIVERS > 1) ? $clog2(N_RECEIVERS) : 1,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk_96MHz,
    input  logic                   reset,
    input  logic [N_RECEIVERS-1:0] e_in,
    input  logic [N_RECEIVERS-1:0] d_in_0,
    input  logic [N_RECEIVERS-1:0] d_in_1,
    input  logic [TS_WIDTH-1:0]    system_timestamp,
    input  logic [N_RECEIVERS-1:0] channel_enable,
    output logic [N_RECEIVERS-1:0] envelop_output_enable,
    output logic [N_RECEIVERS-1:0] envelop_output,
    output logic [N_RECEIVERS-1:0] data_output_enable,
    output logic [N_RECEIVERS-1:0] data_output,
    output logic [N_RECEIVERS-1:0] configured,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_channel,
    output logic [DATA_BITS-1:0]   out_data,
    output logic [TS_WIDTH-1:0]    out_timestamp,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    input  logic                   clear_overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CH_W + DATA_BITS + TS_WIDTH;

    logic [N_RECEIVERS-1:0] da, da_q, new_res, pending, grant_oh, drop_vec;
    logic [DATA_BITS-1:0]   dec_data  [N_RECEIVERS];
    logic [TS_WIDTH-1:0]    dec_ts    [N_RECEIVERS];
    logic [DATA_BITS-1:0]   slot_data [N_RECEIVERS];
    logic [TS_WIDTH-1:0]    slot_ts   [N_RECEIVERS];

    logic [CH_W-1:0]  rr_ptr, grant_idx;
    logic             grant_valid, fifo_full, pop;
    logic [8:0]       drop_sum;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;

    for (genvar i = 0; i < N_RECEIVERS; i++) begin : g_ch
        ts4231_configurator u_cfg (
            .clk                   (clk_96MHz),
            .e_in                  (e_in[i]),
            .d_in                  (d_in_0[i]),
            .envelop_output_enable (envelop_output_enable[i]),
            .envelop_output        (envelop_output[i]),
            .data_output_enable    (data_output_enable[i]),
            .data_output           (data_output[i]),
            .configured            (configured[i])
        );

        bmc_decoder #(
            .bit_considered (DATA_BITS),
            .TS_WIDTH       (TS_WIDTH)
        ) u_dec (
            .clk                 (clk_96MHz),
            .reset               (reset),
            .d_in_0              (d_in_0[i]),
            .d_in_1              (d_in_1[i]),
            .e_in                (e_in[i]),
            .enabled             (configured[i]),
            .system_timestamp    (system_timestamp),
            .decoded_data        (dec_data[i]),
            .data_availible      (da[i]),
            .timestamp_last_data (dec_ts[i])
        );
    end

    assign new_res   = da & ~da_q & channel_enable & configured;
    assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign fifo_level = level;

    // Round-robin search starting at rr_ptr; full is taken from registered
    // level only, so a pop never frees a slot for a push in the same cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!fifo_full) begin
            for (int k = 0; k < N_RECEIVERS; k++) begin
                if (!grant_valid && pending[(int'(rr_ptr) + k) % N_RECEIVERS]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'((int'(rr_ptr) + k) % N_RECEIVERS);
                end
            end
        end
        grant_oh = grant_valid ? (N_RECEIVERS'(1) << grant_idx) : '0;
    end

    // A capture into a slot that is being granted this cycle is a hand-off, not a drop.
    assign drop_vec = new_res & pending & ~grant_oh;

    always_comb begin
        drop_sum = clear_overflow ? 9'd0 : {1'b0, drop_count};
        for (int i = 0; i < N_RECEIVERS; i++) begin
            drop_sum = drop_sum + 9'(drop_vec[i]);
        end
    end

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            da_q       <= '0;
            pending    <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < N_RECEIVERS; i++) begin
                slot_data[i] <= '0;
                slot_ts[i]   <= '0;
            end
        end else begin
            da_q <= da;
            for (int i = 0; i < N_RECEIVERS; i++) begin
                if (new_res[i]) begin
                    slot_data[i] <= dec_data[i];
                    slot_ts[i]   <= dec_ts[i];
                    pending[i]   <= 1'b1;
                end else if (grant_oh[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (grant_valid) begin
                rr_ptr <= (int'(grant_idx) == N_RECEIVERS - 1) ? '0 : grant_idx + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant_valid, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            overflow   <= (overflow & ~clear_overflow) | (|drop_vec);
            drop_count <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        end
    end

    // Storage array carries no reset; outputs are gated by out_valid instead.
    always_ff @(posedge clk_96MHz) begin
        if (grant_valid) begin
            mem[wr_ptr] <= {grant_idx, slot_data[grant_idx], slot_ts[grant_idx]};
        end
    end

    assign {out_channel, out_data, out_timestamp} = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/multi_receiver_manager.md
Name: multi_receiver_manager

Overview:
Parametrised successor to the per-receiver manager. Instantiates N_RECEIVERS TS4231 front-ends, each with a ts4231_configurator and a bmc_decoder (bit_considered = DATA_BITS). Each channel's decoded words are captured into a per-channel holding slot. A round-robin arbiter merges the slots into one shared FWFT FIFO, and a valid/ready stream delivers {channel, data, timestamp} to the downstream packetiser.

Parameters:
N_RECEIVERS, 4, number of receiver channels (1..16)
DATA_BITS, 17, decoded word width passed to bmc_decoder bit_considered
TS_WIDTH, 24, timestamp width
FIFO_DEPTH, 8, shared FIFO entries; power of two, >= 2
CH_W, max(1, clog2(N_RECEIVERS)), channel index width (derived localparam)

Ports:
clk_96MHz  in  1  system clock, 96 MHz
reset  in  1  asynchronous, active-high reset
e_in  in  N_RECEIVERS  envelope inputs, one per receiver
d_in_0  in  N_RECEIVERS  data inputs, one per receiver
d_in_1  in  N_RECEIVERS  second data sample inputs, one per receiver
system_timestamp  in  TS_WIDTH  free-running system time
channel_enable  in  N_RECEIVERS  per-channel capture enable
envelop_output_enable  out  N_RECEIVERS  configurator pad control, per channel
envelop_output  out  N_RECEIVERS  configurator pad drive, per channel
data_output_enable  out  N_RECEIVERS  configurator pad control, per channel
data_output  out  N_RECEIVERS  configurator pad drive, per channel
configured  out  N_RECEIVERS  per-channel configurator done
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_channel  out  CH_W  channel index of head entry
out_data  out  DATA_BITS  decoded word of head entry
out_timestamp  out  TS_WIDTH  timestamp_last_data of head entry
fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky drop flag
drop_count  out  8  saturating drop counter
clear_overflow  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset: reset is asynchronous and active-high.
  - Cleared on reset: all pending flags, holding slots, FIFO pointers and level. out_valid=0, out_channel/out_data/out_timestamp=0, overflow=0, drop_count=0. Round-robin pointer selects channel 0 as highest priority.
  - reset is forwarded to every bmc_decoder. Configurators have no reset; configured bits persist across reset.
- Per-channel wiring: the configurator's configured output drives the decoder's enabled input and the configured output port. Pad outputs pass straight through.
- Capture:
  - da_q[i] registers the decoder's data_availible.
  - A new result on channel i is da[i] & ~da_q[i] & channel_enable[i] & configured[i].
  - On a new result: latch decoded_data and timestamp_last_data into slot i and set pending[i].
- Slot collision:
  - New result while pending[i]=1 and slot i not granted this cycle: overwrite the slot (freshest wins), set overflow, increment drop_count (saturates at 255).
  - New result in the same cycle slot i is granted: old contents go to the FIFO, new contents are latched, pending stays 1, no drop.
- Arbiter:
  - Each cycle where the FIFO is not full and any pending bit is set, grant the first pending channel at or after rr_ptr (wrapping).
  - On a grant: push {g, slot g}, clear pending[g] (unless re-captured the same cycle), set rr_ptr = g+1 mod N_RECEIVERS.
  - At most one push per cycle.
  - The full check uses registered state only; no same-cycle pop-to-push bypass.
- FIFO: first-word fall-through.
  - out_valid = (level != 0); pop on out_valid & out_ready.
  - Simultaneous push and pop: level unchanged.
  - out_* hold stable while out_valid & ~out_ready.
- Latency, empty FIFO, no contention: data_availible first sampled high at edge N → slot written at edge N, pushed at edge N+1, out_valid high after edge N+1.
- channel_enable deasserted: suppresses new captures only; an already-pending slot still drains.
- clear_overflow: clears overflow and drop_count. If a drop occurs in the same cycle, result is overflow=1, drop_count=1.

Test Plan:
- Reset, N=4: configure ch0; pulse ch0 data_availible with data 0x1A5A5, ts 0x000123 → out_valid 2 cycles later; out_channel=0, out_data=0x1A5A5, out_timestamp=0x000123; fifo_level returns to 0 after pop.
- Simultaneous capture on ch0..ch3, out_ready=1 → four entries in order ch0,ch1,ch2,ch3. Then rr_ptr=0, so repeating the burst yields ch0 first again.
- out_ready=0 with 10 results spread over 4 channels, FIFO_DEPTH=8 → fifo_level saturates at 8; extra results wait in slots; two overwrites → drop_count=2, overflow=1; releasing out_ready drains 8+pending entries with no loss beyond those counted.
- Second result on ch2 before its slot is granted (FIFO full) → slot holds the newer word, drop_count increments; clear_overflow in the same cycle as a drop → drop_count=1, overflow=1.
- channel_enable[1]=0 with ch1 pulses → no entries for ch1; a ch1 slot pending before disable still emerges.
- Assert reset mid-burst with 5 entries queued → out_valid=0 and fifo_level=0 immediately (asynchronously); configured bits unchanged; next capture behaves as after the first reset.
